// File: rtl/addsub_sequencer_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package addsub_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int NIB_W = 4;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_sequencer_nibble_addsub.sv
// 4-bit ripple add/subtract slice; cin is explicit so nibbles chain through
// an external carry register rather than being seeded from m here.
module nibble_addsub
   import addsub_sequencer_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             m,
   input  logic             cin,
   output logic [NIB_W-1:0] s,
   output logic             cout
);

   logic [NIB_W-1:0] bm;
   logic [NIB_W:0]   c;

   assign bm   = b ^ {NIB_W{m}};
   assign c[0] = cin;

   for (genvar gi = 0; gi < NIB_W; gi++) begin : g_bit
      full_adder u_fa (
         .a    (a[gi]),
         .b    (bm[gi]),
         .cin  (c[gi]),
         .s    (s[gi]),
         .cout (c[gi+1])
      );
   end

   assign cout = c[NIB_W];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/addsub_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract that reuses one nibble slice,
// least-significant nibble first, carrying between nibbles in carry_q.
module addsub_sequencer
   import addsub_sequencer_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             m,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int NIBBLES = WIDTH / NIB_W;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               m_q, m_d;
   logic [WIDTH-1:0]   s_q, s_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   logic [NIB_W-1:0]   a_nibs [NIBBLES];
   logic [NIB_W-1:0]   b_nibs [NIBBLES];
   logic [NIB_W-1:0]   nib_s;
   logic               nib_cout;

   for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nibs[gi] = a_q[gi*NIB_W +: NIB_W];
      assign b_nibs[gi] = b_q[gi*NIB_W +: NIB_W];
   end

   nibble_addsub u_slice (
      .a    (a_nibs[idx_q]),
      .b    (b_nibs[idx_q]),
      .m    (m_q),
      .cin  (carry_q),
      .s    (nib_s),
      .cout (nib_cout)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      m_d     = m_q;
      s_d     = s_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               m_d     = m;
               // Subtraction is a + ~b + 1, so the +1 enters as the first carry.
               carry_d = (m == MODE_SUB);
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            s_d[int'(idx_q)*NIB_W +: NIB_W] = nib_s;
            carry_d = nib_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               cout_d  = nib_cout;
               ovf_d   = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ m_q)) &&
                         (nib_s[NIB_W-1] != a_q[WIDTH-1]);
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         m_q     <= 1'b0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         m_q     <= m_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign s    = s_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule
